// File: rtl/battleship_pkg.sv
// battleship_pkg
// Shared types and constants for the battleship turn sequencer:
//   - GRID_BITS : bits per row/column coordinate (8x8 grid)
//   - player_t  : 1-bit player id (0 = P1, 1 = P2)
//   - state_t   : turn sequencer FSM states
//   - count_w   : width needed to hold a hit count 0..n
//   - timer_w   : width of the shared down-counter (holds max(a,b)-1)
package battleship_pkg;

    localparam int GRID_BITS = 3;

    typedef logic player_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_AIM      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RESULT   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    function automatic int count_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // The timer is only ever loaded with (limit - 1), so $clog2(limit) bits suffice.
    function automatic int timer_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/turn_timer.sv
// turn_timer
// Loadable down-counter with a zero flag. Shared by the aiming timeout and
// the result display hold.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : load load_val_i this cycle (takes priority over en_i)
//   load_val_i   : value to load
//   en_i         : decrement by one; saturates at zero
//   zero_o       : counter currently equals zero
module turn_timer #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/battle_turn_sequencer.sv
// battle_turn_sequencer
// Two-player turn controller: starts a game on restart_pulse, alternates
// turns, latches the aimed cell on fire, queries the board store, tallies
// hits and declares a winner once a player has sunk every ship cell.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   restart_pulse                 : new-game request (honoured in IDLE/DONE)
//   fire_btn, cursor_row/col      : fire pulse and current aim cell
//   shot_req/target/row/col       : board query (request side)
//   shot_ack/hit/repeat           : board response
//   idle_state, active_player     : game status
//   show_result, last_hit         : shot-result display
//   hits_p1, hits_p2              : per-player hit counts
//   game_over, winner             : end-of-game status
//   state_dbg                     : current FSM state (observability)
//
// Board handshake: shot_req is a level that rises the cycle after a fire is
// accepted and stays high, together with shot_target/row/col held stable,
// until the cycle in which shot_ack is sampled high; shot_hit and
// shot_repeat are only looked at in that same cycle. shot_ack seen in any
// other state is ignored.
module battle_turn_sequencer
    import battleship_pkg::*;
#(
    parameter int SHIP_CELLS   = 17,
    parameter int TURN_TIMEOUT = 50_000_000,
    parameter int SHOW_CYCLES  = 25_000_000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              restart_pulse,
    input  logic                              fire_btn,
    input  logic [GRID_BITS-1:0]              cursor_row,
    input  logic [GRID_BITS-1:0]              cursor_col,
    output logic                              shot_req,
    output logic                              shot_target,
    output logic [GRID_BITS-1:0]              shot_row,
    output logic [GRID_BITS-1:0]              shot_col,
    input  logic                              shot_ack,
    input  logic                              shot_hit,
    input  logic                              shot_repeat,
    output logic                              idle_state,
    output logic                              active_player,
    output logic                              show_result,
    output logic                              last_hit,
    output logic [$clog2(SHIP_CELLS+1)-1:0]   hits_p1,
    output logic [$clog2(SHIP_CELLS+1)-1:0]   hits_p2,
    output logic                              game_over,
    output logic                              winner,
    output state_t                            state_dbg
);

    localparam int CW = $clog2(SHIP_CELLS + 1);
    localparam int TW = timer_w(TURN_TIMEOUT, SHOW_CYCLES);

    localparam logic [CW-1:0] SHIP_MAX  = CW'(SHIP_CELLS);
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_TIMEOUT - 1);
    localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);

    state_t                state_q, state_d;
    player_t               player_q, player_d;
    player_t               winner_q, winner_d;
    logic                  req_q, req_d;
    logic                  target_q, target_d;
    logic [GRID_BITS-1:0]  row_q, row_d;
    logic [GRID_BITS-1:0]  col_q, col_d;
    logic                  idle_q, idle_d;
    logic                  show_q, show_d;
    logic                  last_hit_q, last_hit_d;
    logic                  game_over_q, game_over_d;
    logic [CW-1:0]         hits_p1_q, hits_p1_d;
    logic [CW-1:0]         hits_p2_q, hits_p2_d;

    logic                  tmr_load;
    logic [TW-1:0]         tmr_load_val;
    logic                  tmr_en;
    logic                  tmr_zero;

    logic [CW-1:0]         active_hits;

    turn_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    assign active_hits = player_q ? hits_p2_q : hits_p1_q;

    always_comb begin
        state_d      = state_q;
        player_d     = player_q;
        winner_d     = winner_q;
        req_d        = req_q;
        target_d     = target_q;
        row_d        = row_q;
        col_d        = col_q;
        idle_d       = idle_q;
        show_d       = show_q;
        last_hit_d   = last_hit_q;
        game_over_d  = game_over_q;
        hits_p1_d    = hits_p1_q;
        hits_p2_d    = hits_p2_q;
        tmr_load     = 1'b0;
        tmr_load_val = TURN_LOAD;
        tmr_en       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (restart_pulse) begin
                    state_d     = ST_AIM;
                    player_d    = 1'b0;
                    winner_d    = 1'b0;
                    hits_p1_d   = '0;
                    hits_p2_d   = '0;
                    last_hit_d  = 1'b0;
                    game_over_d = 1'b0;
                    idle_d      = 1'b0;
                    tmr_load    = 1'b1;
                end
            end

            ST_AIM: begin
                // A fire in the timeout cycle takes precedence over the forfeit.
                if (fire_btn) begin
                    row_d    = cursor_row;
                    col_d    = cursor_col;
                    target_d = ~player_q;
                    req_d    = 1'b1;
                    state_d  = ST_WAIT_ACK;
                end else if (tmr_zero) begin
                    player_d = ~player_q;
                    tmr_load = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_WAIT_ACK: begin
                if (shot_ack) begin
                    req_d = 1'b0;
                    if (shot_repeat) begin
                        // Wasted shot on an already-fired cell: same player retries.
                        state_d  = ST_AIM;
                        tmr_load = 1'b1;
                    end else begin
                        last_hit_d = shot_hit;
                        if (shot_hit) begin
                            if (player_q) begin
                                hits_p2_d = hits_p2_q + 1'b1;
                            end else begin
                                hits_p1_d = hits_p1_q + 1'b1;
                            end
                        end
                        show_d       = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = SHOW_LOAD;
                        state_d      = ST_RESULT;
                    end
                end
            end

            ST_RESULT: begin
                if (tmr_zero) begin
                    show_d = 1'b0;
                    // Hit counts were updated on entry, so active_hits is current.
                    if (active_hits == SHIP_MAX) begin
                        state_d     = ST_DONE;
                        game_over_d = 1'b1;
                        idle_d      = 1'b1;
                        winner_d    = player_q;
                    end else begin
                        player_d = ~player_q;
                        tmr_load = 1'b1;
                        state_d  = ST_AIM;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                idle_d  = 1'b1;
                req_d   = 1'b0;
                show_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            player_q    <= 1'b0;
            winner_q    <= 1'b0;
            req_q       <= 1'b0;
            target_q    <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            idle_q      <= 1'b1;
            show_q      <= 1'b0;
            last_hit_q  <= 1'b0;
            game_over_q <= 1'b0;
            hits_p1_q   <= '0;
            hits_p2_q   <= '0;
        end else begin
            state_q     <= state_d;
            player_q    <= player_d;
            winner_q    <= winner_d;
            req_q       <= req_d;
            target_q    <= target_d;
            row_q       <= row_d;
            col_q       <= col_d;
            idle_q      <= idle_d;
            show_q      <= show_d;
            last_hit_q  <= last_hit_d;
            game_over_q <= game_over_d;
            hits_p1_q   <= hits_p1_d;
            hits_p2_q   <= hits_p2_d;
        end
    end

    assign shot_req      = req_q;
    assign shot_target   = target_q;
    assign shot_row      = row_q;
    assign shot_col      = col_q;
    assign idle_state    = idle_q;
    assign active_player = player_q;
    assign show_result   = show_q;
    assign last_hit      = last_hit_q;
    assign hits_p1       = hits_p1_q;
    assign hits_p2       = hits_p2_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_battle_turn_sequencer.sv
// Directed bench for battle_turn_sequencer with SHIP_CELLS=2,
// TURN_TIMEOUT=20, SHOW_CYCLES=4.
module tb_battle_turn_sequencer;
    import battleship_pkg::*;

    localparam int SHIP_CELLS   = 2;
    localparam int TURN_TIMEOUT = 20;
    localparam int SHOW_CYCLES  = 4;
    localparam int CW           = $clog2(SHIP_CELLS + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 restart_pulse;
    logic                 fire_btn;
    logic [GRID_BITS-1:0] cursor_row;
    logic [GRID_BITS-1:0] cursor_col;
    logic                 shot_req;
    logic                 shot_target;
    logic [GRID_BITS-1:0] shot_row;
    logic [GRID_BITS-1:0] shot_col;
    logic                 shot_ack;
    logic                 shot_hit;
    logic                 shot_repeat;
    logic                 idle_state;
    logic                 active_player;
    logic                 show_result;
    logic                 last_hit;
    logic [CW-1:0]        hits_p1;
    logic [CW-1:0]        hits_p2;
    logic                 game_over;
    logic                 winner;
    state_t               state_dbg;

    battle_turn_sequencer #(
        .SHIP_CELLS   (SHIP_CELLS),
        .TURN_TIMEOUT (TURN_TIMEOUT),
        .SHOW_CYCLES  (SHOW_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .restart_pulse (restart_pulse),
        .fire_btn      (fire_btn),
        .cursor_row    (cursor_row),
        .cursor_col    (cursor_col),
        .shot_req      (shot_req),
        .shot_target   (shot_target),
        .shot_row      (shot_row),
        .shot_col      (shot_col),
        .shot_ack      (shot_ack),
        .shot_hit      (shot_hit),
        .shot_repeat   (shot_repeat),
        .idle_state    (idle_state),
        .active_player (active_player),
        .show_result   (show_result),
        .last_hit      (last_hit),
        .hits_p1       (hits_p1),
        .hits_p2       (hits_p2),
        .game_over     (game_over),
        .winner        (winner),
        .state_dbg     (state_dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard of expected shot requests {target,row,col}.
    logic [2*GRID_BITS:0] exp_q[$];

    task automatic expect_shot(input logic tgt, input logic [GRID_BITS-1:0] r,
                               input logic [GRID_BITS-1:0] c);
        exp_q.push_back({tgt, r, c});
    endtask

    task automatic observe_shot();
        logic [2*GRID_BITS:0] e;
        check_eq("shot_q_size", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("shot_fields", {shot_target, shot_row, shot_col}, e);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_restart();
        restart_pulse = 1'b1;
        tick();
        restart_pulse = 1'b0;
    endtask

    task automatic fire_at(input logic [GRID_BITS-1:0] r, input logic [GRID_BITS-1:0] c,
                           input logic exp_tgt);
        cursor_row = r;
        cursor_col = c;
        fire_btn   = 1'b1;
        expect_shot(exp_tgt, r, c);
        tick();
        fire_btn = 1'b0;
        check_eq("fire_req", shot_req, 1);
        check_eq("fire_state", state_dbg, ST_WAIT_ACK);
        observe_shot();
    endtask

    task automatic send_ack(input logic hit, input logic rep);
        shot_ack    = 1'b1;
        shot_hit    = hit;
        shot_repeat = rep;
        tick();
        shot_ack    = 1'b0;
        shot_hit    = 1'b0;
        shot_repeat = 1'b0;
    endtask

    // Counts sampled cycles with show_result high; bounded.
    task automatic count_show(output int n);
        n = 0;
        while (show_result && n < 20) begin
            n++;
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    int n;

    initial begin
        rst_n         = 1'b0;
        restart_pulse = 1'b0;
        fire_btn      = 1'b0;
        cursor_row    = '0;
        cursor_col    = '0;
        shot_ack      = 1'b0;
        shot_hit      = 1'b0;
        shot_repeat   = 1'b0;

        // 1. reset and start
        ticks(3);
        check_eq("rst_idle", idle_state, 1);
        check_eq("rst_state", state_dbg, ST_IDLE);
        check_eq("rst_req", shot_req, 0);
        check_eq("rst_player", active_player, 0);
        check_eq("rst_hits", {hits_p1, hits_p2}, 0);
        check_eq("rst_over", {game_over, winner, show_result, last_hit}, 0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_hold", state_dbg, ST_IDLE);
        pulse_restart();
        check_eq("start_idle", idle_state, 0);
        check_eq("start_state", state_dbg, ST_AIM);
        check_eq("start_player", active_player, 0);
        check_eq("start_hits", {hits_p1, hits_p2}, 0);

        // 2. P1 hits at (3,5), 7-cycle ack delay; restart mid-wait is ignored
        fire_at(3'd3, 3'd5, 1'b1);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) restart_pulse = 1'b1;
            if (i == 4) fire_btn = 1'b1;
            tick();
            restart_pulse = 1'b0;
            fire_btn      = 1'b0;
            check_eq("wait_req", shot_req, 1);
            check_eq("wait_hold", {shot_target, shot_row, shot_col}, {1'b1, 3'd3, 3'd5});
        end
        check_eq("wait_state", state_dbg, ST_WAIT_ACK);
        send_ack(1'b1, 1'b0);
        check_eq("hit_req_drop", shot_req, 0);
        check_eq("hit_p1", hits_p1, 1);
        check_eq("hit_last", last_hit, 1);
        check_eq("hit_state", state_dbg, ST_RESULT);
        count_show(n);
        check_eq("show_len", n, SHOW_CYCLES);
        check_eq("after_hit_player", active_player, 1);
        check_eq("after_hit_state", state_dbg, ST_AIM);

        // 3. P2 repeat shot at (0,0)
        fire_at(3'd0, 3'd0, 1'b0);
        send_ack(1'b0, 1'b1);
        check_eq("rep_state", state_dbg, ST_AIM);
        check_eq("rep_player", active_player, 1);
        check_eq("rep_hits", {hits_p1, hits_p2}, {2'd1, 2'd0});
        check_eq("rep_last", last_hit, 1);
        check_eq("rep_req", shot_req, 0);

        // 4a. forfeit after TURN_TIMEOUT idle cycles (timer reloaded by the repeat)
        n = 0;
        while (active_player == 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check_eq("forfeit_cycles", n, TURN_TIMEOUT);
        check_eq("forfeit_state", state_dbg, ST_AIM);

        // 4b. fire exactly in the timeout cycle: fire wins, no toggle
        ticks(TURN_TIMEOUT - 1);
        check_eq("pre_edge_player", active_player, 0);
        fire_at(3'd2, 3'd6, 1'b1);
        check_eq("edge_player", active_player, 0);

        // 5. P1 second hit wins
        send_ack(1'b1, 1'b0);
        check_eq("win_p1", hits_p1, 2);
        check_eq("win_p2", hits_p2, 0);
        count_show(n);
        check_eq("win_show_len", n, SHOW_CYCLES);
        check_eq("win_state", state_dbg, ST_DONE);
        check_eq("win_over", game_over, 1);
        check_eq("win_winner", winner, 0);
        check_eq("win_idle", idle_state, 1);
        fire_btn = 1'b1;
        tick();
        fire_btn = 1'b0;
        tick();
        check_eq("done_fire_req", shot_req, 0);
        check_eq("done_fire_state", state_dbg, ST_DONE);
        send_ack(1'b1, 1'b0);
        check_eq("done_ack_hits", {hits_p1, hits_p2}, {2'd2, 2'd0});
        pulse_restart();
        check_eq("rs_state", state_dbg, ST_AIM);
        check_eq("rs_hits", {hits_p1, hits_p2}, 0);
        check_eq("rs_flags", {game_over, winner, idle_state, last_hit}, 0);
        check_eq("rs_player", active_player, 0);

        // 6. reset during WAIT_ACK drops shot_req asynchronously
        fire_at(3'd1, 3'd1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_req", shot_req, 0);
        check_eq("async_state", state_dbg, ST_IDLE);
        check_eq("async_idle", idle_state, 1);
        tick();
        rst_n = 1'b1;
        send_ack(1'b1, 1'b0);
        check_eq("late_ack_hits", {hits_p1, hits_p2}, 0);
        check_eq("late_ack_state", state_dbg, ST_IDLE);
        check_eq("late_ack_last", last_hit, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
